// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if: request/ack buses of both masters plus the SRAM pin group
interface sram_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              m0_req;
    logic              m0_we;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic [DATA_W-1:0] m0_rdata;
    logic              m0_ack;
    logic              m1_req;
    logic              m1_we;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic [DATA_W-1:0] m1_rdata;
    logic              m1_ack;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wdata;
    logic              sram_mem_ena;
    logic              sram_wr_ena;
    logic [DATA_W-1:0] sram_rdata;

    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata, m1_req, m1_we, m1_addr, m1_wdata, sram_rdata,
        output m0_rdata, m0_ack, m1_rdata, m1_ack, sram_addr, sram_wdata, sram_mem_ena, sram_wr_ena
    );

    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata, m1_req, m1_we, m1_addr, m1_wdata, sram_rdata,
        input  m0_rdata, m0_ack, m1_rdata, m1_ack, sram_addr, sram_wdata, sram_mem_ena, sram_wr_ena
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: serializes two masters onto one SRAM port; SRAM_ARB_ROUND_ROBIN_EN selects round-robin over fixed priority
module sram_port_arbiter #(
    parameter int ACCESS_CYCLES = 2,
    parameter int ADDR_W        = 16,
    parameter int DATA_W        = 16
) (
    input  logic                clk,
    input  logic                reset,
    sram_port_arbiter_if.slave  bus,
    output logic                owner,
    output logic                busy
);
    localparam int CW = ACCESS_CYCLES > 1 ? $clog2(ACCESS_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state, state_d;
    logic [CW-1:0]     cnt, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              ena_q, ena_d, wr_q, wr_d;
    logic              ack0_q, ack0_d, ack1_q, ack1_d;
    logic              owner_d;
    logic [DATA_W-1:0] r0_q, r0_d, r1_q, r1_d;
    logic              any_req, pick;

    assign any_req = bus.m0_req | bus.m1_req;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic ptr, ptr_d;
    assign pick = (bus.m0_req & bus.m1_req) ? ptr : bus.m1_req;
`else
    assign pick = ~bus.m0_req & bus.m1_req;
`endif

    // next state and next values of every registered output
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ena_d   = ena_q;
        wr_d    = wr_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        owner_d = owner;
        r0_d    = r0_q;
        r1_d    = r1_q;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        ptr_d   = ptr;
`endif
        case (state)
            IDLE: begin
                state_d = any_req ? ACCESS : IDLE;
                owner_d = any_req ? pick : owner;
                addr_d  = any_req ? (pick ? bus.m1_addr : bus.m0_addr) : '0;
                wdata_d = any_req ? (pick ? bus.m1_wdata : bus.m0_wdata) : '0;
                wr_d    = any_req & (pick ? bus.m1_we : bus.m0_we);
                ena_d   = any_req;
                cnt_d   = CW'(ACCESS_CYCLES - 1);
            end
            ACCESS: begin
                if (cnt == '0) begin
                    state_d = DONE;
                    ena_d   = 1'b0;
                    wr_d    = 1'b0;
                    ack0_d  = ~owner;
                    ack1_d  = owner;
                    r0_d    = (!wr_q && !owner) ? bus.sram_rdata : r0_q;
                    r1_d    = (!wr_q && owner) ? bus.sram_rdata : r1_q;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
                ptr_d   = ~owner;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // state and output registers; reset aborts any access immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            ena_q   <= 1'b0;
            wr_q    <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            owner   <= 1'b0;
            r0_q    <= '0;
            r1_q    <= '0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            ptr     <= 1'b0;
`endif
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ena_q   <= ena_d;
            wr_q    <= wr_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            owner   <= owner_d;
            r0_q    <= r0_d;
            r1_q    <= r1_d;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
            ptr     <= ptr_d;
`endif
        end
    end

    assign busy             = state != IDLE;
    assign bus.sram_addr    = addr_q;
    assign bus.sram_wdata   = wdata_q;
    assign bus.sram_mem_ena = ena_q;
    assign bus.sram_wr_ena  = wr_q;
    assign bus.m0_ack       = ack0_q;
    assign bus.m1_ack       = ack1_q;
    assign bus.m0_rdata     = r0_q;
    assign bus.m1_rdata     = r1_q;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: directed transactions with an ack scoreboard for sram_port_arbiter
module tb_sram_port_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic owner, busy;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic        who;
        logic [15:0] r0;
        logic [15:0] r1;
    } exp_t;
    exp_t sb[$];

    sram_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    sram_port_arbiter #(.ACCESS_CYCLES(2), .ADDR_W(16), .DATA_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .owner (owner),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // SRAM model: one fixed word, everything else reads back the inverted address
    assign bus.sram_rdata = (bus.sram_addr == 16'h1234) ? 16'hBEEF : ~bus.sram_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_ack(input logic who, input logic [15:0] r0, input logic [15:0] r1);
        exp_t e;
        e.who = who;
        e.r0  = r0;
        e.r1  = r1;
        sb.push_back(e);
    endtask

    // monitor: every ack pops one expected completion
    always @(negedge clk) begin
        if (bus.m0_ack || bus.m1_ack) begin
            if (sb.size() == 0) begin
                check("unexpected_ack", {30'd0, bus.m1_ack, bus.m0_ack}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ack_owner", {30'd0, bus.m1_ack, bus.m0_ack}, e.who ? 32'd2 : 32'd1);
                check("m0_rdata", {16'd0, bus.m0_rdata}, {16'd0, e.r0});
                check("m1_rdata", {16'd0, bus.m1_rdata}, {16'd0, e.r1});
            end
        end
    end

    task automatic run_txn(input logic m, input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                           output int lat, output int ena_n, output int wr_n, output int bad_bus);
        lat = 0; ena_n = 0; wr_n = 0; bad_bus = 0;
        if (m) begin
            bus.m1_req = 1'b1; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata;
        end else begin
            bus.m0_req = 1'b1; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata;
        end
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.sram_mem_ena) begin
                ena_n++;
                if (bus.sram_wr_ena) wr_n++;
                if (bus.sram_addr != addr || (we && bus.sram_wdata != wdata)) bad_bus++;
            end
            if (bus.m0_ack || bus.m1_ack) begin
                lat = i;
                break;
            end
        end
        bus.m0_req = 1'b0;
        bus.m1_req = 1'b0;
    endtask

    initial begin
        int lat, ena_n, wr_n, bad_bus, acks, first, last;
        logic [15:0] r1_exp;
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 16'h0400; bus.m0_wdata = 16'h0;
        bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 16'h0500; bus.m1_wdata = 16'h0;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sram_addr", {16'd0, bus.sram_addr}, 32'd0);
        check("rst_enables", {30'd0, bus.sram_mem_ena, bus.sram_wr_ena}, 32'd0);
        check("rst_acks", {30'd0, bus.m0_ack, bus.m1_ack}, 32'd0);
        check("rst_rdata", {bus.m0_rdata, bus.m1_rdata}, 32'd0);
        check("rst_owner_busy", {30'd0, owner, busy}, 32'd0);

        // release with both requesting: master 0 wins first
        expect_ack(1'b0, 16'hFBFF, 16'h0000);
        reset = 1'b1;
        @(posedge clk); #1;
        check("first_grant", {29'd0, owner, busy, bus.sram_mem_ena}, 32'b011);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.m0_ack || bus.m1_ack) begin lat = 1; break; end
        end
        bus.m0_req = 1'b0; bus.m1_req = 1'b0;
        check("first_ack_seen", lat, 32'd1);
        @(negedge clk);

        // master 0 read
        expect_ack(1'b0, 16'hBEEF, 16'h0000);
        run_txn(1'b0, 1'b0, 16'h1234, 16'h0, lat, ena_n, wr_n, bad_bus);
        check("rd_latency", lat, 32'd3);
        check("rd_ena_cycles", ena_n, 32'd2);
        check("rd_wr_cycles", wr_n, 32'd0);
        check("rd_bus", bad_bus, 32'd0);
        @(negedge clk);

        // master 1 write leaves m1_rdata alone
        expect_ack(1'b1, 16'hBEEF, 16'h0000);
        run_txn(1'b1, 1'b1, 16'h00FF, 16'hA5A5, lat, ena_n, wr_n, bad_bus);
        check("wr_latency", lat, 32'd3);
        check("wr_ena_cycles", ena_n, 32'd2);
        check("wr_wr_cycles", wr_n, 32'd2);
        check("wr_bus", bad_bus, 32'd0);
        @(negedge clk);

        // both masters reading continuously for four grants
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        expect_ack(1'b0, 16'hFEFF, 16'h0000);
        expect_ack(1'b1, 16'hFEFF, 16'hFDFF);
        expect_ack(1'b0, 16'hFEFF, 16'hFDFF);
        expect_ack(1'b1, 16'hFEFF, 16'hFDFF);
        r1_exp = 16'hFDFF;
`else
        repeat (4) expect_ack(1'b0, 16'hFEFF, 16'h0000);
        r1_exp = 16'h0000;
`endif
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 16'h0100;
        bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 16'h0200;
        acks = 0; first = 0; last = 0;
        for (int i = 1; i <= 60 && acks < 4; i++) begin
            @(negedge clk);
            if (bus.m0_ack || bus.m1_ack) begin
                acks++;
                if (acks == 1) first = i;
                last = i;
            end
        end
        bus.m0_req = 1'b0; bus.m1_req = 1'b0;
        check("burst_acks", acks, 32'd4);
        check("burst_span", last - first, 32'd12);
        @(negedge clk);

        // address change during ACCESS is ignored
        expect_ack(1'b0, 16'hFFEF, r1_exp);
        bus.m0_req = 1'b1; bus.m0_we = 1'b0; bus.m0_addr = 16'h0010;
        @(negedge clk);
        check("hold_addr_c1", {15'd0, bus.sram_mem_ena, bus.sram_addr}, {15'd0, 1'b1, 16'h0010});
        bus.m0_addr = 16'h0020;
        @(negedge clk);
        check("hold_addr_c2", {15'd0, bus.sram_mem_ena, bus.sram_addr}, {15'd0, 1'b1, 16'h0010});
        @(negedge clk);
        check("hold_ack", {31'd0, bus.m0_ack}, 32'd1);
        bus.m0_req = 1'b0;
        @(negedge clk);

        // reset in the second ACCESS cycle aborts without ack
        bus.m1_req = 1'b1; bus.m1_we = 1'b0; bus.m1_addr = 16'h0300;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_ena", {30'd0, bus.sram_mem_ena, busy}, 32'd0);
        bus.m1_req = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_acks", {30'd0, bus.m0_ack, bus.m1_ack}, 32'd0);
        check("abort_rdata", {bus.m0_rdata, bus.m1_rdata}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        expect_ack(1'b1, 16'h0000, 16'hFCFF);
        run_txn(1'b1, 1'b0, 16'h0300, 16'h0, lat, ena_n, wr_n, bad_bus);
        check("rereq_latency", lat, 32'd3);
        check("rereq_ena_cycles", ena_n, 32'd2);
        repeat (2) @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
